// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: 2-entry in-order head/skid queue between fetch and decode.
// Define IFID_PERF_CNT_EN to add the saturating decode back-pressure counter (stall_count).
module if_id_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instruction,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  input  logic        out_ready
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] head_instr_q, head_instr_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            accept;
  logic            pop;

  // Handshakes decode from registered occupancy only; no out_ready -> in_ready path.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_instruction = out_valid ? head_instr_q : NOP_INSTR;
  assign out_pc          = out_valid ? head_pc_q    : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // Occupancy transitions; flush overrides both the offered entry and the pop.
  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            head_instr_d = in_instruction;
            head_pc_d    = in_pc;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_instr_d = in_instruction;
            head_pc_d    = in_pc;
          end else if (accept) begin
            state_d      = FULL;
            skid_instr_d = in_instruction;
            skid_pc_d    = in_pc;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d      = ONE;
            head_instr_d = skid_instr_q;
            head_pc_d    = skid_pc_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic stall_inc;

  // Counts every stalled edge regardless of flush, saturating at all-ones.
  assign stall_inc = out_valid && !out_ready && (stall_count != {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (stall_inc) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed vector table, async reset, random traffic vs queue model.
// Define IFID_PERF_CNT_EN to also exercise stall_count.
module tb_if_id_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instruction;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        out_ready;
`ifdef IFID_PERF_CNT_EN
  logic [15:0] stall_count;
`endif

  if_id_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_instruction  (in_instruction),
    .in_pc           (in_pc),
    .in_ready        (in_ready),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_ready       (out_ready)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [15:0] mcnt = '0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] epc;
    logic        eir;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'hCAFE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares DUT outputs with the queue model; in_ready must not follow out_ready.
  task automatic check_model();
    logic        ev;
    logic [31:0] epc;
    ev  = (q.size() > 0);
    epc = ev ? q[0] : 32'h0;
    chk("model_out_valid", 32'(out_valid), 32'(ev));
    chk("model_out_pc", out_pc, epc);
    chk("model_out_instr", out_instruction, ev ? ins_of(epc) : NOP);
    chk("model_in_ready", 32'(in_ready), 32'(q.size() < 2));
`ifdef IFID_PERF_CNT_EN
    chk("model_stall_count", 32'(stall_count), 32'(mcnt));
`endif
    out_ready = ~out_ready;
    #1;
    chk("in_ready_indep", 32'(in_ready), 32'(q.size() < 2));
    out_ready = ~out_ready;
  endtask

  // One clock: drive inputs, advance model with pre-edge occupancy, check after the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
    int sz;
    bit acc, pp;
    in_valid       = v;
    in_pc          = pc;
    in_instruction = ins_of(pc);
    out_ready      = ordy;
    flush          = fl;
    sz  = q.size();
    acc = v && (sz < 2);
    pp  = ordy && (sz > 0);
    @(posedge clk);
    if (sz > 0 && !ordy && mcnt != 16'hFFFF) mcnt++;
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(pc);
    end
    #1;
    check_model();
  endtask

  task automatic reset_pulse();
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    q.delete();
    mcnt = '0;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instruction, NOP);
`ifdef IFID_PERF_CNT_EN
    chk("rst_stall_count", 32'(stall_count), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_pc = '0;
    in_instruction = '0;
    out_ready = 1'b0;
    flush = 1'b0;

    // streaming, back-pressure, drain, flush-in-FULL, flush-in-ONE
    vecs[0]  = '{1'b1, 32'h000, 1'b1, 1'b0, 1'b1, 32'h000, 1'b1};
    vecs[1]  = '{1'b1, 32'h004, 1'b1, 1'b0, 1'b1, 32'h004, 1'b1};
    vecs[2]  = '{1'b1, 32'h008, 1'b1, 1'b0, 1'b1, 32'h008, 1'b1};
    vecs[3]  = '{1'b1, 32'h00C, 1'b1, 1'b0, 1'b1, 32'h00C, 1'b1};
    vecs[4]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000, 1'b1};
    vecs[5]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1};
    vecs[6]  = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0};
    vecs[7]  = '{1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0};
    vecs[8]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h104, 1'b1};
    vecs[9]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000, 1'b1};
    vecs[10] = '{1'b1, 32'h110, 1'b0, 1'b0, 1'b1, 32'h110, 1'b1};
    vecs[11] = '{1'b1, 32'h114, 1'b0, 1'b0, 1'b1, 32'h110, 1'b0};
    vecs[12] = '{1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h000, 1'b1};
    vecs[13] = '{1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1};
    vecs[14] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000, 1'b1};
    vecs[15] = '{1'b1, 32'h500, 1'b0, 1'b0, 1'b1, 32'h500, 1'b1};
    vecs[16] = '{1'b1, 32'h400, 1'b1, 1'b1, 1'b0, 32'h000, 1'b1};
    vecs[17] = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    chk("reset_out_pc", out_pc, 32'h0);
    chk("reset_out_instr", out_instruction, NOP);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_model();

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].epc);
      chk($sformatf("vec%0d_out_instr", i), out_instruction,
          vecs[i].ev ? ins_of(vecs[i].epc) : NOP);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].eir));
    end

    // async reset while ONE, asserted between edges
    step(1'b1, 32'h600, 1'b0, 1'b0);
    chk("pre_rst_out_pc", out_pc, 32'h600);
    reset_pulse();

    // random traffic; PCs strictly increase so order/loss/duplication shows in out_pc
    begin
      logic [31:0] pc;
      pc = 32'h1000;
      for (int n = 0; n < 400; n++) begin
        step(($urandom_range(0, 3) != 0), pc, $urandom_range(0, 1) == 1,
             ($urandom_range(0, 19) == 0));
        pc += 32'h4;
      end
    end

`ifdef IFID_PERF_CNT_EN
    reset_pulse();
    step(1'b1, 32'h700, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    mcnt = 16'hFFFF;
    chk("stall_saturated", 32'(stall_count), 32'h0000_FFFF);
    step(1'b1, 32'h800, 1'b0, 1'b1);
    chk("stall_after_flush", 32'(stall_count), 32'h0000_FFFF);
    reset_pulse();
    chk("stall_after_rst", 32'(stall_count), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
